sa_out_drain: RTL and testbench

// - Downstream of the 16x16 array controller/array: captures one column of 16 signed partial sums per

---
 rtl/sa_out_drain_if.sv | 25 ++
 rtl/sa_out_drain.sv | 163 ++++++++++++++++
 tb/tb_sa_out_drain.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sa_out_drain_if.sv
// Output byte stream of sa_out_drain: valid/ready handshake carrying one requantized lane per beat.
// master = producer (the drain), slave = consumer.
interface sa_out_drain_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] out_lane;
    logic       out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_lane,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_lane,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/sa_out_drain.sv
// Ping-pong drain of systolic-array psum columns: captures LANES psums, requantizes to 8 bits and
// streams one byte per beat. Define OUT_RELU_EN to clamp negative results to zero before saturation.
module sa_out_drain #(
    parameter int unsigned LANES = 16,
    parameter int unsigned ACCW  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  cap,
    input  logic [LANES*ACCW-1:0] psums,
    input  logic [4:0]            qshift,
    sa_out_drain_if.master        stream,
    output logic                  busy,
    output logic                  ovf,
    output logic [15:0]           sat_cnt
);
    localparam int unsigned LW = $clog2(LANES);
    localparam int unsigned PW = LW + 1;
    localparam int unsigned XW = ACCW + 1;

    localparam logic signed [XW-1:0] SatMax = XW'(127);
    localparam logic signed [XW-1:0] SatMin = -XW'(128);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    logic [ACCW-1:0] bank_q    [2][LANES];
    logic [4:0]      bank_qs_q [2];
    logic [1:0]      full_q;
    logic            wr_q;
    logic            rd_q;
    logic [PW-1:0]   ptr_q;
    state_e          state_q;

    logic            out_valid_q;
    logic [7:0]      out_data_q;
    logic [3:0]      out_lane_q;
    logic            out_last_q;
    logic            ovf_q;
    logic [15:0]     sat_cnt_q;

    logic [ACCW-1:0]       lane_val;
    logic [4:0]            sh;
    logic signed [XW-1:0]  ext;
    logic signed [XW-1:0]  rnd;
    logic signed [XW-1:0]  shifted;
    logic [7:0]            qbyte;
    logic                  qsat;
    logic                  slot;
    logic                  can_load;
    logic                  release_col;

    // Requantize the lane the pointer currently addresses in the read bank.
    always_comb begin
        lane_val = bank_q[rd_q][ptr_q[LW-1:0]];
        sh       = bank_qs_q[rd_q];
        ext      = {lane_val[ACCW-1], lane_val};
        rnd      = ext;
        shifted  = ext;
        if (sh != 5'd0) begin
            rnd     = ext + (XW'(1) << (sh - 5'd1));
            shifted = rnd >>> sh;
        end
        qsat  = 1'b0;
        qbyte = shifted[7:0];
`ifdef OUT_RELU_EN
        if (shifted < 0) begin
            qbyte = 8'h00;
        end else if (shifted > SatMax) begin
            qbyte = 8'h7f;
            qsat  = 1'b1;
        end
`else
        if (shifted > SatMax) begin
            qbyte = 8'h7f;
            qsat  = 1'b1;
        end else if (shifted < SatMin) begin
            qbyte = 8'h80;
            qsat  = 1'b1;
        end
`endif
    end

    always_comb begin
        slot        = !out_valid_q || stream.out_ready;
        can_load    = enable && full_q[rd_q] && (ptr_q != PW'(LANES)) && slot;
        // All lanes loaded and the last one is gone (or leaving now): free the bank.
        release_col = enable && (state_q == StStream) && (ptr_q == PW'(LANES)) && slot;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q      <= 2'b00;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            ptr_q       <= '0;
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_lane_q  <= 4'h0;
            out_last_q  <= 1'b0;
            ovf_q       <= 1'b0;
            sat_cnt_q   <= 16'h0000;
        end else begin
            // The consumer can always retire a pending beat, even while frozen.
            if (out_valid_q && stream.out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (enable) begin
                if (cap) begin
                    if (!full_q[wr_q]) begin
                        for (int i = 0; i < int'(LANES); i++) begin
                            bank_q[wr_q][i] <= psums[i*ACCW +: ACCW];
                        end
                        bank_qs_q[wr_q] <= qshift;
                        full_q[wr_q]    <= 1'b1;
                        wr_q            <= ~wr_q;
                    end else begin
                        ovf_q <= 1'b1;
                    end
                end

                if (can_load) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= qbyte;
                    out_lane_q  <= ptr_q[LW-1:0];
                    out_last_q  <= (ptr_q == PW'(LANES - 1));
                    ptr_q       <= ptr_q + PW'(1);
                    if (qsat) begin
                        sat_cnt_q <= sat_cnt_q + 16'd1;
                    end
                end

                unique case (state_q)
                    StIdle: begin
                        if (can_load) begin
                            state_q <= StStream;
                        end
                    end
                    StStream: begin
                        if (release_col) begin
                            full_q[rd_q] <= 1'b0;
                            rd_q         <= ~rd_q;
                            ptr_q        <= '0;
                            state_q      <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign stream.out_valid = out_valid_q;
    assign stream.out_data  = out_data_q;
    assign stream.out_lane  = out_lane_q;
    assign stream.out_last  = out_last_q;

    assign busy    = full_q[0] | full_q[1] | out_valid_q;
    assign ovf     = ovf_q;
    assign sat_cnt = sat_cnt_q;
endmodule

// File: tb/tb_sa_out_drain.sv
// Bench for sa_out_drain: directed steps plus random columns, scored against a column-queue model.
// Honours OUT_RELU_EN the same way as the design build.
module tb_sa_out_drain;
    localparam int LANES = 16;
    localparam int ACCW  = 24;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  enable;
    logic                  cap;
    logic [LANES*ACCW-1:0] psums;
    logic [4:0]            qshift;
    logic                  busy;
    logic                  ovf;
    logic [15:0]           sat_cnt;

    sa_out_drain_if sif ();

    always #5 clk = ~clk;

    sa_out_drain #(
        .LANES(LANES),
        .ACCW (ACCW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .cap    (cap),
        .psums  (psums),
        .qshift (qshift),
        .stream (sif),
        .busy   (busy),
        .ovf    (ovf),
        .sat_cnt(sat_cnt)
    );

    typedef struct {
        logic [7:0] data;
        logic [3:0] lane;
        logic       last;
    } beat_t;

    beat_t      expq[$];
    int         pend;
    logic       exp_ovf;
    int         exp_sat;
    int         checks;
    int         failures;

    bit         have_prev;
    logic       prev_v;
    logic       prev_r;
    logic [7:0] prev_d;
    logic [3:0] prev_l;
    logic       prev_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requantization straight from the arithmetic definition, using wide integers.
    function automatic void model_req(input logic signed [ACCW-1:0] x, input int q,
                                      output logic [7:0] b, output bit s);
        longint r;
        r = longint'(x);
        if (q != 0) r = (r + (longint'(1) << (q - 1))) >>> q;
        s = 1'b0;
`ifdef OUT_RELU_EN
        if (r < 0) r = 0;
`endif
        if (r > 127) begin
            r = 127;
            s = 1'b1;
        end else if (r < -128) begin
            r = -128;
            s = 1'b1;
        end
        b = r[7:0];
    endfunction

    task automatic push_col(input logic [LANES*ACCW-1:0] ps, input int q);
        logic [7:0] b;
        bit         s;
        for (int i = 0; i < LANES; i++) begin
            model_req(ps[i*ACCW +: ACCW], q, b, s);
            expq.push_back('{data: b, lane: 4'(i), last: (i == LANES - 1)});
            if (s) exp_sat++;
        end
    endtask

    // One clock: inputs already driven; observe outputs, advance model, move to next negedge.
    task automatic cycle();
        beat_t e;
        if (!rst) begin
            if (have_prev && prev_v && !prev_r) begin
                chk("hold_valid", sif.out_valid, 1);
                chk("hold_data", sif.out_data, prev_d);
                chk("hold_lane", sif.out_lane, prev_l);
                chk("hold_last", sif.out_last, prev_last);
            end
            if (cap && enable) begin
                if (pend < 2) begin
                    push_col(psums, int'(qshift));
                    pend++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
            if (sif.out_valid && sif.out_ready) begin
                if (expq.size() == 0) begin
                    chk("spurious_beat", 32'(expq.size()), 32'd1);
                end else begin
                    e = expq.pop_front();
                    chk("beat_data", sif.out_data, e.data);
                    chk("beat_lane", sif.out_lane, e.lane);
                    chk("beat_last", sif.out_last, e.last);
                    if (e.last) pend--;
                end
            end
        end else begin
            expq.delete();
            pend    = 0;
            exp_ovf = 1'b0;
            exp_sat = 0;
        end
        have_prev = !rst;
        prev_v    = sif.out_valid;
        prev_r    = sif.out_ready;
        prev_d    = sif.out_data;
        prev_l    = sif.out_lane;
        prev_last = sif.out_last;
        @(negedge clk);
    endtask

    task automatic do_cap(input logic [LANES*ACCW-1:0] ps, input logic [4:0] q);
        psums  = ps;
        qshift = q;
        cap    = 1'b1;
        cycle();
        cap    = 1'b0;
    endtask

    task automatic drain(input int mode, input int budget);
        int n;
        n = 0;
        while ((expq.size() != 0 || busy) && n < budget) begin
            case (mode)
                0:       sif.out_ready = 1'b1;
                1:       sif.out_ready = n[0];
                default: sif.out_ready = 1'($urandom_range(0, 1));
            endcase
            cycle();
            n++;
        end
        chk("drain_empty", 32'(expq.size()), 32'd0);
        chk("drain_idle", busy, 0);
    endtask

    task automatic gen(output logic [LANES*ACCW-1:0] ps);
        logic signed [ACCW-1:0] v;
        for (int i = 0; i < LANES; i++) begin
            v = ACCW'($urandom);
            v = v >>> $urandom_range(0, 20);
            ps[i*ACCW +: ACCW] = v;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LANES*ACCW-1:0] ps;
        checks    = 0;
        failures  = 0;
        have_prev = 0;
        expq.delete();
        pend      = 0;
        exp_ovf   = 1'b0;
        exp_sat   = 0;
        rst       = 1'b1;
        enable    = 1'b1;
        cap       = 1'b0;
        psums     = '0;
        qshift    = 5'd0;
        sif.out_ready = 1'b0;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;

        // Reset state
        chk("rst_valid", sif.out_valid, 0);
        chk("rst_data", sif.out_data, 0);
        chk("rst_lane", sif.out_lane, 0);
        chk("rst_last", sif.out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_sat", sat_cnt, 0);

        // Ramp column, lane i = i*256 >> 8 -> i; lane 0 appears two cycles after cap
        for (int i = 0; i < LANES; i++) ps[i*ACCW +: ACCW] = ACCW'(i * 256);
        sif.out_ready = 1'b1;
        do_cap(ps, 5'd8);
        chk("lat_t1_valid", sif.out_valid, 0);
        cycle();
        chk("lat_t2_valid", sif.out_valid, 1);
        chk("lat_t2_lane", sif.out_lane, 0);
        chk("lat_t2_data", sif.out_data, 0);
        drain(0, 100);
        chk("ramp_sat", sat_cnt, 0);

        // Rounding and saturation
        ps = '0;
        ps[0*ACCW +: ACCW] = ACCW'(383);
        ps[1*ACCW +: ACCW] = ACCW'(-385);
        ps[2*ACCW +: ACCW] = 24'h7fffff;
        do_cap(ps, 5'd8);
        drain(0, 100);
        chk("round_sat_cnt", sat_cnt, 1);

        // Negative clip, qshift 0
        ps = '0;
        ps[0*ACCW +: ACCW] = ACCW'(-1000);
        ps[1*ACCW +: ACCW] = ACCW'(1000);
        ps[2*ACCW +: ACCW] = ACCW'(-128);
        do_cap(ps, 5'd0);
        drain(1, 100);
`ifdef OUT_RELU_EN
        chk("relu_sat_cnt", sat_cnt, 2);
`else
        chk("signed_sat_cnt", sat_cnt, 3);
`endif
        chk("sat_cnt_model", sat_cnt, 32'(exp_sat));

        // Three back-to-back caps with consumer stalled: third is dropped
        sif.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            gen(ps);
            do_cap(ps, 5'(4 + c));
        end
        chk("ovf_set", ovf, exp_ovf);
        chk("ovf_value", ovf, 1);
        chk("stall_lane", sif.out_lane, 0);
        for (int c = 0; c < 4; c++) cycle();
        drain(0, 200);
        chk("ovf_sticky", ovf, 1);

        // Freeze: pending beat still retires, nothing new loads
        gen(ps);
        do_cap(ps, 5'd6);
        cycle();
        cycle();
        chk("frz_pre_valid", sif.out_valid, 1);
        enable        = 1'b0;
        sif.out_ready = 1'b1;
        cycle();
        chk("frz_valid_fall", sif.out_valid, 0);
        cycle();
        chk("frz_no_load", sif.out_valid, 0);
        chk("frz_busy", busy, 1);
        enable = 1'b1;
        drain(2, 300);

        // Reset in the middle of a stream
        gen(ps);
        sif.out_ready = 1'b1;
        do_cap(ps, 5'd10);
        for (int n = 0; n < 20 && !(sif.out_valid && sif.out_lane == 4'd7); n++) cycle();
        chk("reach_lane7", sif.out_lane, 7);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_rst_valid", sif.out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ovf", ovf, 0);
        gen(ps);
        do_cap(ps, 5'd3);
        cycle();
        chk("restart_lane", sif.out_lane, 0);
        chk("restart_valid", sif.out_valid, 1);
        drain(0, 100);

        // Random captures against a random consumer
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 60; c++) begin
                sif.out_ready = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 5) == 0) begin
                    gen(ps);
                    psums  = ps;
                    qshift = 5'($urandom_range(0, 23));
                    cap    = 1'b1;
                end
                cycle();
                cap = 1'b0;
            end
            drain(2, 600);
            chk("rand_ovf", ovf, exp_ovf);
            chk("rand_sat", sat_cnt, 32'(exp_sat));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
